seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, meaning clk cycles each digit is driven (legal 1..2^20).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port load  input  1  one-cycle strobe capturing bcd and dp_in.
REQ-005 The block SHALL have port bcd  input  16  four BCD digits, [3:0]=digit0 (rightmost) ... [15:12]=digit3.
REQ-006 The block SHALL have port dp_in  input  4  decimal-point enable per digit, bit n = digit n.
REQ-007 The block SHALL have port an  output  4  digit enables, active-low, one-hot-low while scanning.
REQ-008 The block SHALL have port seg  output  7  segments a..g, active-low, [6]=a ... [0]=g.
REQ-009 The block SHALL have port dp  output  1  decimal point, active-low.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Function
REQ-011 FSM SHALL have two states: IDLE (an=4'b1111, seg=7'b1111111, dp=1) and SCAN.
REQ-012 IDLE -> SCAN SHALL occur on the first load; the loaded value SHALL be copied directly to the shadow register; the first SCAN cycle drives digit 0.
REQ-013 In SCAN a prescaler SHALL count 0..CLK_DIV-1; at terminal count the digit index SHALL advance 0->1->2->3->0 and the prescaler SHALL wrap to 0.
REQ-014 an SHALL drive low only bit [index]; seg and dp SHALL reflect shadow digit [index] in the same cycle (combinational decode, zero latency from index).
REQ-015 Decoding SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100; codes 10..15 SHALL give 1111111.
REQ-016 dp SHALL equal ~dp_shadow[index].
REQ-017 In SCAN, load SHALL write a pending register and set pending_valid; successive loads before frame end: last wins.
REQ-018 At the terminal count with index=3, frame_done SHALL pulse and the shadow SHALL take the pending value if pending_valid (then clear it); otherwise keep its value.
REQ-019 load coincident with REQ-018 boundary: the load value SHALL go directly to the shadow (load wins over pending); pending_valid SHALL clear.
REQ-020 A displayed frame SHALL never mix old and new values (no tearing).
REQ-021 CLK_DIV=1 SHALL advance index every cycle; frame_done SHALL then pulse every 4th cycle.

Reset
REQ-022 rst SHALL asynchronously force IDLE, index=0, prescaler=0, shadow=0, pending=0, pending_valid=0, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
REQ-023 rst mid-frame SHALL discard pending data; display SHALL stay blank until the next load.

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined, digits 3..1 SHALL output seg=1111111 (an still asserted) when they and all higher digits are 0 and their dp bit is 0; digit 0 SHALL never blank.
REQ-025 Without LEADING_ZERO_BLANK_EN, every digit SHALL be decoded per REQ-015.

Structure
REQ-026 Shared package seg_pkg SHALL hold the state enum (IDLE, SCAN), SEG_BLANK=7'b1111111, AN_OFF=4'b1111 and the digit-count constant 4.
REQ-027 Decode SHALL be the existing sub-module bin_to_seg, instantiated once, extended externally for codes 10..15 blanking.

Verification (CLK_DIV=4)
REQ-028 Reset, no load, 100 cycles -> an=1111, seg=1111111, dp=1, frame_done never pulses.
REQ-029 load bcd=16'h1234, dp_in=4'b0010 -> digit0 seg=1001100 an=1110 for 4 cycles, then digit1 seg=0000110 dp=0 an=1101, digit2, digit3 seg=1001111; frame_done at cycle 16.
REQ-030 Mid-frame loads 16'h5555 then 16'h9999 -> current frame unchanged; next frame shows 9999 only.
REQ-031 load 16'h00A7 at frame boundary cycle -> next frame digit0=0001111, digit1=1111111; with LEADING_ZERO_BLANK_EN digits 3,2 blank, else 0000001.
REQ-032 rst asserted mid-digit-2 with pending load -> outputs blank asynchronously; after release stays IDLE until new load.
REQ-033 CLK_DIV=1, load 16'h8888 -> an cycles 1110,1101,1011,0111 each cycle, seg=0000000, frame_done every 4 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    function automatic logic is_bcd(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display bus bundle: data/strobe from the producer, scan outputs from the controller.
interface seg_scan_ctrl_if;

    logic        load;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output load, bcd, dp_in,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  load, bcd, dp_in,
        output an, seg, dp, frame_done
    );

endinterface

// File: rtl/bin_to_seg.sv
// 4-bit to active-low seven-segment decoder, [6]=a ... [0]=g; 10..15 give hex glyphs.
module bin_to_seg (
    input  logic [3:0] i_bin,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_bin)
            4'd0:    o_seg = 7'b0000001;
            4'd1:    o_seg = 7'b1001111;
            4'd2:    o_seg = 7'b0010010;
            4'd3:    o_seg = 7'b0000110;
            4'd4:    o_seg = 7'b1001100;
            4'd5:    o_seg = 7'b0100100;
            4'd6:    o_seg = 7'b0100000;
            4'd7:    o_seg = 7'b0001111;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0001100;
            4'd10:   o_seg = 7'b0001000;
            4'd11:   o_seg = 7'b1100000;
            4'd12:   o_seg = 7'b0110001;
            4'd13:   o_seg = 7'b1000010;
            4'd14:   o_seg = 7'b0110000;
            default: o_seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit BCD display scanner with tear-free frame-boundary updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned       PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]     TERM = PW'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_DIGITS - 1);

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_shadow;
    logic [15:0]      r_pending;
    logic [3:0]       r_dp_shadow;
    logic [3:0]       r_dp_pending;
    logic             r_pend_valid;

    logic             w_term;
    logic             w_frame_end;
    logic [3:0]       w_digit;
    logic             w_dp_bit;
    logic [6:0]       w_dec_seg;
    logic             w_lz_blank;

    assign w_term      = (r_presc == TERM);
    assign w_frame_end = (r_state == SCAN) && w_term && (r_idx == LAST);
    assign w_digit     = r_shadow[{r_idx, 2'b00} +: 4];
    assign w_dp_bit    = r_dp_shadow[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_pending    <= '0;
            r_dp_shadow  <= '0;
            r_dp_pending <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_state     <= SCAN;
                        r_shadow    <= bcd;
                        r_dp_shadow <= dp_in;
                        r_idx       <= '0;
                        r_presc     <= '0;
                    end
                end
                SCAN: begin
                    if (w_term) begin
                        r_presc <= '0;
                        r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                    // Shadow only changes at the frame boundary; a coincident load beats pending data.
                    if (w_frame_end) begin
                        if (load) begin
                            r_shadow     <= bcd;
                            r_dp_shadow  <= dp_in;
                            r_pend_valid <= 1'b0;
                        end else if (r_pend_valid) begin
                            r_shadow     <= r_pending;
                            r_dp_shadow  <= r_dp_pending;
                            r_pend_valid <= 1'b0;
                        end
                    end else if (load) begin
                        r_pending    <= bcd;
                        r_dp_pending <= dp_in;
                        r_pend_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bin_to_seg u_bin_to_seg (
        .i_bin (w_digit),
        .o_seg (w_dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every higher digit are zero and no dp is lit here.
    assign w_lz_blank = (r_idx != '0) && ((r_shadow >> {r_idx, 2'b00}) == 16'h0) && !w_dp_bit;
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        an         = AN_OFF;
        seg        = SEG_BLANK;
        dp         = 1'b1;
        frame_done = w_frame_end;
        if (r_state == SCAN) begin
            an  = ~(4'b0001 << r_idx);
            seg = (!is_bcd(w_digit) || w_lz_blank) ? SEG_BLANK : w_dec_seg;
            dp  = ~w_dp_bit;
        end
    end

endmodule
